clangpu_exec_ctrl: RTL and testbench

//   Program-load and run sequencer for the ClangPU core. On START it copies PROG_LEN

---
 rtl/clangpu_exec_ctrl.sv | 163 ++++++++++++++++
 tb/tb_clangpu_exec_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clangpu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// clangpu_exec_ctrl
//   Program-load and run sequencer for the ClangPU core. On START it copies
//   PROG_LEN words from a word-wide source memory into the core instruction
//   memory, then raises CEXEC. It holds CEXEC until the core reports
//   completion on CSTAT or until a cycle timeout expires. It also reports the
//   length of the run.
//
// Ports
//   CCLK, CRST         clock; asynchronous active-high reset
//   START, ABORT       run request (taken in IDLE/FIN); abort back to IDLE
//   PROG_BASE/LEN      source byte address of word 0; number of words to load
//   SRC_REQ/ADDR/ACK/DATA
//                      source read handshake (REQ held until ACK)
//   IMEM_WE/ADDR/WDATA instruction memory write port (one-cycle strobe)
//   CEXEC, CSTAT       core run enable; core finished flag
//   BUSY, DONE         loading/running; run finished (held)
//   TIMEOUT_ERR        run ended by the cycle timeout
//   CYCLE_CNT          RUN cycles of the last/current run, saturating
// -----------------------------------------------------------------------------
module clangpu_exec_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int IMEM_AW        = 10,
  parameter int SRC_AW         = 32,
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 4500
) (
  input  logic                  CCLK,
  input  logic                  CRST,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [SRC_AW-1:0]     PROG_BASE,
  input  logic [IMEM_AW:0]      PROG_LEN,
  output logic                  SRC_REQ,
  output logic [SRC_AW-1:0]     SRC_ADDR,
  input  logic                  SRC_ACK,
  input  logic [DATA_WIDTH-1:0] SRC_DATA,
  output logic                  IMEM_WE,
  output logic [IMEM_AW-1:0]    IMEM_ADDR,
  output logic [DATA_WIDTH-1:0] IMEM_WDATA,
  output logic                  CEXEC,
  input  logic                  CSTAT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  TIMEOUT_ERR,
  output logic [CNT_W-1:0]      CYCLE_CNT
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam bit TIMEOUT_EN     = (TIMEOUT_CYCLES != 0);

  logic [2:0]            state_q, state_d;
  logic [SRC_AW-1:0]     base_q,  base_d;
  logic [IMEM_AW:0]      len_q,   len_d;
  logic [IMEM_AW:0]      idx_q,   idx_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  tout_q,  tout_d;

  logic [CNT_W-1:0]      cnt_inc;
  logic [SRC_AW-1:0]     src_offset;

  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign src_offset = SRC_AW'(idx_q) * SRC_AW'(BYTES_PER_WORD);

  // All outputs decode registered state, so reset clears them immediately
  // and no strobe can leak out in the cycle reset is asserted.
  assign SRC_REQ     = (state_q == ST_FETCH);
  assign SRC_ADDR    = SRC_REQ ? (base_q + src_offset) : '0;
  assign IMEM_WE     = (state_q == ST_WRITE);
  assign IMEM_ADDR   = IMEM_WE ? idx_q[IMEM_AW-1:0] : '0;
  assign IMEM_WDATA  = IMEM_WE ? data_q : '0;
  assign CEXEC       = (state_q == ST_RUN);
  assign BUSY        = (state_q == ST_FETCH) || (state_q == ST_WRITE) || (state_q == ST_RUN);
  assign DONE        = (state_q == ST_FIN);
  assign TIMEOUT_ERR = tout_q;
  assign CYCLE_CNT   = cnt_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;

    if (ABORT) begin
      state_d = ST_IDLE;
      tout_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FIN: begin
          if (START) begin
            base_d  = PROG_BASE;
            len_d   = PROG_LEN;
            idx_d   = '0;
            cnt_d   = '0;
            tout_d  = 1'b0;
            state_d = (PROG_LEN != '0) ? ST_FETCH : ST_RUN;
          end
        end
        ST_FETCH: begin
          if (SRC_ACK) begin
            data_d  = SRC_DATA;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (idx_q == len_q - 1'b1) begin
            state_d = ST_RUN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_RUN: begin
          cnt_d = cnt_inc;
          // The counter is cleared on START, so zero marks the first RUN
          // cycle, where CSTAT may still be left over from a previous run.
          if ((cnt_q != '0) && CSTAT) begin
            state_d = ST_FIN;
          end else if (TIMEOUT_EN && (64'(cnt_inc) == 64'(TIMEOUT_CYCLES))) begin
            state_d = ST_FIN;
            tout_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge CCLK or posedge CRST) begin
    if (CRST) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
    end
  end

endmodule

// File: tb/tb_clangpu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clangpu_exec_ctrl
//   Directed bench for clangpu_exec_ctrl: program load with 0- and 3-cycle
//   source latency, CSTAT completion, timeout, CSTAT/timeout tie, ABORT in
//   FETCH and RUN, START while busy, zero-length program and mid-load reset.
//   A single process drives inputs and samples outputs on the falling edge.
// -----------------------------------------------------------------------------
module tb_clangpu_exec_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int SAW = 32;
  localparam int CW  = 24;
  localparam int TMO = 4500;
  localparam logic [DW-1:0] DATA0 = 32'h4d20_0093;

  logic           CCLK = 1'b0;
  logic           CRST, START, ABORT, SRC_ACK, CSTAT;
  logic [SAW-1:0] PROG_BASE;
  logic [AW:0]    PROG_LEN;
  logic [DW-1:0]  SRC_DATA;
  logic           SRC_REQ, IMEM_WE, CEXEC, BUSY, DONE, TIMEOUT_ERR;
  logic [SAW-1:0] SRC_ADDR;
  logic [AW-1:0]  IMEM_ADDR;
  logic [DW-1:0]  IMEM_WDATA;
  logic [CW-1:0]  CYCLE_CNT;

  clangpu_exec_ctrl #(
    .DATA_WIDTH(DW), .IMEM_AW(AW), .SRC_AW(SAW), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CCLK(CCLK), .CRST(CRST), .START(START), .ABORT(ABORT),
    .PROG_BASE(PROG_BASE), .PROG_LEN(PROG_LEN),
    .SRC_REQ(SRC_REQ), .SRC_ADDR(SRC_ADDR), .SRC_ACK(SRC_ACK), .SRC_DATA(SRC_DATA),
    .IMEM_WE(IMEM_WE), .IMEM_ADDR(IMEM_ADDR), .IMEM_WDATA(IMEM_WDATA),
    .CEXEC(CEXEC), .CSTAT(CSTAT), .BUSY(BUSY), .DONE(DONE),
    .TIMEOUT_ERR(TIMEOUT_ERR), .CYCLE_CNT(CYCLE_CNT)
  );

  always #5 CCLK = ~CCLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source-memory responder and write/request monitor state.
  bit             resp_en;
  int             ack_lat, wait_cnt;
  logic [SAW-1:0] base_v;
  logic [AW-1:0]  we_addr[$];
  logic [DW-1:0]  we_data[$];
  logic [SAW-1:0] addr_log[$];
  int             req_cyc, load_cyc;
  bit             last_req;
  logic [SAW-1:0] last_addr;

  task automatic clear_logs();
    we_addr.delete();
    we_data.delete();
    addr_log.delete();
    req_cyc  = 0;
    load_cyc = 0;
  endtask

  // Advance to the next falling edge, answer the source request and log.
  task automatic tick();
    @(negedge CCLK);
    SRC_ACK = 1'b0;
    if (resp_en && SRC_REQ) begin
      if (wait_cnt >= ack_lat) begin
        SRC_ACK  = 1'b1;
        SRC_DATA = DATA0 + ((SRC_ADDR - base_v) >> 2);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    if (IMEM_WE) begin
      we_addr.push_back(IMEM_ADDR);
      we_data.push_back(IMEM_WDATA);
    end
    if (SRC_REQ) begin
      req_cyc++;
      if (!last_req || SRC_ADDR != last_addr) addr_log.push_back(SRC_ADDR);
    end
    if (BUSY && !CEXEC) load_cyc++;
    last_req  = SRC_REQ;
    last_addr = SRC_ADDR;
  endtask

  task automatic start_prog(input logic [SAW-1:0] base, input logic [AW:0] len);
    base_v    = base;
    PROG_BASE = base;
    PROG_LEN  = len;
    START     = 1'b1;
    tick();
    START     = 1'b0;
  endtask

  task automatic abort_now();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
  endtask

  task automatic wait_cexec(input int bound);
    int n = 0;
    while (!CEXEC && n < bound) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    CRST = 1'b0; START = 1'b0; ABORT = 1'b0; SRC_ACK = 1'b0; CSTAT = 1'b0;
    PROG_BASE = '0; PROG_LEN = '0; SRC_DATA = '0;
    resp_en = 1'b1; ack_lat = 0; wait_cnt = 0; base_v = '0;
    last_req = 1'b0; last_addr = '0;
    clear_logs();

    // Reset state
    #2 CRST = 1'b1;
    #1;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_cexec", CEXEC, 0);
    check("rst_req", SRC_REQ, 0);
    check("rst_we", IMEM_WE, 0);
    check("rst_tout", TIMEOUT_ERR, 0);
    check("rst_cnt", CYCLE_CNT, 0);
    repeat (2) tick();
    CRST = 1'b0;
    tick();

    // 1: four words from 0x100, zero ACK latency
    clear_logs();
    ack_lat = 0;
    start_prog(32'h100, 4);
    wait_cexec(100);
    check("t1_cexec", CEXEC, 1);
    check("t1_load_cyc", load_cyc, 8);
    check("t1_nwr", we_addr.size(), 4);
    check("t1_nreq", addr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < we_addr.size()) begin
        check($sformatf("t1_waddr%0d", i), we_addr[i], i);
        check($sformatf("t1_wdata%0d", i), we_data[i], DATA0 + i);
      end
      if (i < addr_log.size()) check($sformatf("t1_saddr%0d", i), addr_log[i], 32'h100 + 4 * i);
    end
    abort_now();
    check("t1_abort_cexec", CEXEC, 0);
    check("t1_abort_busy", BUSY, 0);

    // 2: two words, ACK latency 3
    clear_logs();
    ack_lat = 3;
    start_prog(32'h200, 2);
    wait_cexec(100);
    check("t2_cexec", CEXEC, 1);
    check("t2_req_cyc", req_cyc, 8);
    check("t2_load_cyc", load_cyc, 10);
    check("t2_nreq", addr_log.size(), 2);
    check("t2_nwr", we_addr.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < addr_log.size()) check($sformatf("t2_saddr%0d", i), addr_log[i], 32'h200 + 4 * i);
      if (i < we_addr.size()) begin
        check($sformatf("t2_waddr%0d", i), we_addr[i], i);
        check($sformatf("t2_wdata%0d", i), we_data[i], DATA0 + i);
      end
    end
    abort_now();
    ack_lat = 0;

    // 3: zero-length program, CSTAT in RUN cycles 1 and 50
    clear_logs();
    start_prog(32'h0, 0);
    check("t3_direct_run", CEXEC, 1);
    check("t3_no_load", load_cyc, 0);
    for (int k = 1; k <= 50; k++) begin
      if (k == 2) check("t3_cstat1_ignored", CEXEC, 1);
      if (k == 50) check("t3_cnt49", CYCLE_CNT, 49);
      CSTAT = (k == 1) || (k == 50);
      tick();
    end
    CSTAT = 1'b0;
    check("t3_done", DONE, 1);
    check("t3_cexec_low", CEXEC, 0);
    check("t3_busy_low", BUSY, 0);
    check("t3_tout", TIMEOUT_ERR, 0);
    check("t3_cnt", CYCLE_CNT, 50);
    check("t3_no_we", we_addr.size(), 0);
    repeat (3) tick();
    check("t3_done_held", DONE, 1);
    abort_now();
    check("t3_abort_done", DONE, 0);
    check("t3_cnt_kept", CYCLE_CNT, 50);

    // 4: timeout, restart from FIN, CSTAT/timeout tie
    start_prog(32'h0, 0);
    n = 0;
    while (!DONE && n < 5000) begin
      if (CEXEC) n++;
      tick();
    end
    check("t4_run_cycles", n, TMO);
    check("t4_done", DONE, 1);
    check("t4_tout", TIMEOUT_ERR, 1);
    check("t4_cnt", CYCLE_CNT, TMO);
    start_prog(32'h0, 0);
    check("t4_restart_done", DONE, 0);
    check("t4_restart_tout", TIMEOUT_ERR, 0);
    check("t4_restart_cnt", CYCLE_CNT, 0);
    check("t4_restart_cexec", CEXEC, 1);
    for (int k = 1; k <= TMO; k++) begin
      CSTAT = (k == TMO);
      tick();
    end
    CSTAT = 1'b0;
    check("t4_tie_done", DONE, 1);
    check("t4_tie_tout", TIMEOUT_ERR, 0);
    check("t4_tie_cnt", CYCLE_CNT, TMO);
    abort_now();

    // 5: ABORT in FETCH, START while busy, late ACK, ABORT in RUN
    clear_logs();
    resp_en = 1'b0;
    start_prog(32'h300, 4);
    tick();
    tick();
    check("t5_req_held", SRC_REQ, 1);
    check("t5_addr_held", SRC_ADDR, 32'h300);
    PROG_BASE = 32'h400;
    START = 1'b1;
    tick();
    START = 1'b0;
    check("t5_start_busy_addr", SRC_ADDR, 32'h300);
    abort_now();
    check("t5_abort_req", SRC_REQ, 0);
    check("t5_abort_busy", BUSY, 0);
    check("t5_abort_we", IMEM_WE, 0);
    SRC_ACK  = 1'b1;
    SRC_DATA = 32'hdead_beef;
    tick();
    check("t5_late_ack_busy", BUSY, 0);
    tick();
    check("t5_late_ack_we", IMEM_WE, 0);
    check("t5_late_ack_nwr", we_addr.size(), 0);
    resp_en = 1'b1;
    start_prog(32'h0, 0);
    tick();
    tick();
    check("t5_run_cnt", CYCLE_CNT, 2);
    START = 1'b1;
    tick();
    START = 1'b0;
    check("t5_start_run_cnt", CYCLE_CNT, 3);
    check("t5_start_run_cexec", CEXEC, 1);
    abort_now();
    check("t5_abort_cexec", CEXEC, 0);
    check("t5_abort_done", DONE, 0);
    check("t5_abort_cnt", CYCLE_CNT, 3);

    // 6: reset in the middle of the load, then a fresh load
    clear_logs();
    start_prog(32'h100, 4);
    repeat (3) tick();
    check("t6_pre_we", IMEM_WE, 1);
    check("t6_pre_waddr", IMEM_ADDR, 1);
    CRST = 1'b1;
    #1;
    check("t6_rst_we", IMEM_WE, 0);
    check("t6_rst_req", SRC_REQ, 0);
    check("t6_rst_busy", BUSY, 0);
    check("t6_rst_waddr", IMEM_ADDR, 0);
    tick();
    CRST = 1'b0;
    tick();
    clear_logs();
    start_prog(32'h100, 4);
    wait_cexec(100);
    check("t6_cexec", CEXEC, 1);
    check("t6_nwr", we_addr.size(), 4);
    check("t6_load_cyc", load_cyc, 8);
    if (addr_log.size() > 0) check("t6_first_saddr", addr_log[0], 32'h100);
    if (we_addr.size() > 0) begin
      check("t6_first_waddr", we_addr[0], 0);
      check("t6_first_wdata", we_data[0], DATA0);
    end
    abort_now();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
